// File: rtl/uart_pkg.sv
// Shared constants, state encodings and divider helper for the UART receive path.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;
  localparam int MID_SAMPLE = 8;

  typedef logic [1:0] state_t;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  // Clocks per oversample tick, truncated.
  function automatic int calc_div(input int clk_hz, input int baud);
    return clk_hz / (baud * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/uart_rx_clk.sv
// Oversample tick generator: one-clock tick every DIV clocks, restartable by clr.
// Tick is combinational from the count register; no handshake.
module uart_rx_clk #(
  parameter int DIV = 651
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver, 16x oversampled; byte lands one clock after the stop-bit mid-sample.
// No backpressure: a byte completing while the holding register is full is dropped and flagged.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_in,
  input  logic       rx_enable,
  input  logic       uld_rx_data,
  output logic [7:0] rx_data,
  output logic       rx_empty,
  output logic       rx_frame_err,
  output logic       rx_overrun
);

  localparam int DIV = calc_div(CLK_HZ, BAUD);

  logic       rs_meta, rs, rs_q;
  logic [1:0] prime;
  logic       uld_q;
  state_t     state;
  logic [3:0] sample_cnt;
  logic [2:0] bit_idx;
  logic [7:0] shreg;
  logic       tick, tick_clr, start_edge, uld_edge;
  logic       mid_start, bit_end, stop_done, good_frame, bad_frame;

  uart_rx_clk #(.DIV(DIV)) u_rx_clk (
    .clk   (clk),
    .reset (reset),
    .clr   (tick_clr),
    .tick  (tick)
  );

  // rs_q only reports a high once the synchronizer holds real line data,
  // so a line stuck low straight out of reset never looks like a start edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rs_meta <= 1'b1;
      rs      <= 1'b1;
      prime   <= 2'b00;
      rs_q    <= 1'b0;
      uld_q   <= 1'b1;
    end else begin
      rs_meta <= rx_in;
      rs      <= rs_meta;
      prime   <= {prime[0], 1'b1};
      rs_q    <= rs & prime[1];
      uld_q   <= uld_rx_data;
    end
  end

  assign start_edge = rs_q & ~rs;
  assign tick_clr   = (state == IDLE) & rx_enable & start_edge;
  assign uld_edge   = uld_rx_data & ~uld_q;
  assign mid_start  = tick & (sample_cnt == 4'(MID_SAMPLE - 1));
  assign bit_end    = tick & (sample_cnt == 4'(OVERSAMPLE - 1));
  assign stop_done  = rx_enable & (state == STOP) & bit_end;
  assign good_frame = stop_done & rs;
  assign bad_frame  = stop_done & ~rs;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      sample_cnt <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
    end else if (!rx_enable) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start_edge) begin
            state      <= START;
            sample_cnt <= '0;
          end
        end
        START: begin
          if (mid_start) begin
            sample_cnt <= '0;
            bit_idx    <= '0;
            state      <= rs ? IDLE : DATA;
          end else if (tick) begin
            sample_cnt <= sample_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            shreg[bit_idx] <= rs;
            sample_cnt     <= '0;
            if (bit_idx == 3'(DATA_BITS - 1)) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else if (tick) begin
            sample_cnt <= sample_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            sample_cnt <= '0;
            state      <= IDLE;
          end else if (tick) begin
            sample_cnt <= sample_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Unload is applied before load, so a same-cycle unload frees the slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data      <= '0;
      rx_empty     <= 1'b1;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
    end else begin
      if (uld_edge) begin
        rx_empty   <= 1'b1;
        rx_overrun <= 1'b0;
      end
      if (good_frame) begin
        if (rx_empty || uld_edge) begin
          rx_data      <= shreg;
          rx_empty     <= 1'b0;
          rx_frame_err <= 1'b0;
        end else begin
          rx_overrun <= 1'b1;
        end
      end
      if (bad_frame) begin
        rx_frame_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboarded bench for uart_receiver at DIV=10 (160 clocks per bit).
module tb_uart_receiver;

  localparam int BIT = 160;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_in;
  logic       rx_enable;
  logic       uld_rx_data;
  logic [7:0] rx_data;
  logic       rx_empty;
  logic       rx_frame_err;
  logic       rx_overrun;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  uart_receiver #(.CLK_HZ(1_600_000), .BAUD(10_000)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_in        (rx_in),
    .rx_enable    (rx_enable),
    .uld_rx_data  (uld_rx_data),
    .rx_data      (rx_data),
    .rx_empty     (rx_empty),
    .rx_frame_err (rx_frame_err),
    .rx_overrun   (rx_overrun)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic hold_bit(input logic v);
    rx_in = v;
    repeat (BIT) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic stop_bit);
    @(posedge clk);
    #1;
    hold_bit(1'b0);
    for (int i = 0; i < 8; i++) hold_bit(b[i]);
    hold_bit(stop_bit);
    rx_in = 1'b1;
    repeat (16) @(posedge clk);
    #1;
  endtask

  task automatic unload();
    @(posedge clk);
    #1 uld_rx_data = 1'b1;
    repeat (2) @(posedge clk);
    #1 uld_rx_data = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Monitor: a byte is presented when rx_empty falls or the held byte changes while full.
  initial begin
    logic       prev_empty;
    logic [7:0] prev_data;
    logic [7:0] e;
    prev_empty = 1'b1;
    prev_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && rx_empty === 1'b0 && (prev_empty || rx_data !== prev_data)) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_byte: got %0h expected none", rx_data);
        end else begin
          e = exp_q.pop_front();
          if (rx_data !== e) begin
            n_err++;
            $display("FAIL byte: got %0h expected %0h", rx_data, e);
          end
        end
      end
      prev_empty = rx_empty;
      prev_data  = rx_data;
    end
  end

  initial begin
    reset       = 1'b0;
    rx_in       = 1'b1;
    rx_enable   = 1'b1;
    uld_rx_data = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_data", rx_data, 8'h00);
    chk("rst_empty", rx_empty, 1);
    chk("rst_ferr", rx_frame_err, 0);
    chk("rst_ovr", rx_overrun, 0);
    reset = 1'b1;
    repeat (20) @(posedge clk);
    #1;

    // Plain byte and unload
    exp_q.push_back(8'hA5);
    send(8'hA5, 1'b1);
    chk("a5_data", rx_data, 8'hA5);
    chk("a5_empty", rx_empty, 0);
    chk("a5_ferr", rx_frame_err, 0);
    chk("a5_ovr", rx_overrun, 0);
    unload();
    chk("a5_uld_empty", rx_empty, 1);
    chk("a5_uld_data", rx_data, 8'hA5);

    // Overrun
    exp_q.push_back(8'h3C);
    send(8'h3C, 1'b1);
    send(8'hC3, 1'b1);
    chk("ovr_data", rx_data, 8'h3C);
    chk("ovr_flag", rx_overrun, 1);
    chk("ovr_empty", rx_empty, 0);
    unload();
    chk("ovr_clr", rx_overrun, 0);
    chk("ovr_uld_empty", rx_empty, 1);

    // Framing error then recovery
    send(8'h55, 1'b0);
    chk("ferr_flag", rx_frame_err, 1);
    chk("ferr_empty", rx_empty, 1);
    exp_q.push_back(8'h0F);
    send(8'h0F, 1'b1);
    chk("ferr_next_data", rx_data, 8'h0F);
    chk("ferr_clr", rx_frame_err, 0);
    unload();

    // Glitch on idle line
    @(posedge clk);
    #1 rx_in = 1'b0;
    repeat (40) @(posedge clk);
    #1 rx_in = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    chk("glitch_empty", rx_empty, 1);
    chk("glitch_ferr", rx_frame_err, 0);
    chk("glitch_ovr", rx_overrun, 0);
    exp_q.push_back(8'h81);
    send(8'h81, 1'b1);
    chk("glitch_next", rx_data, 8'h81);

    // Reset during bit 4 of 0xFF, with 0x81 still held
    fork
      send(8'hFF, 1'b1);
      begin
        repeat (5 * BIT + 80) @(posedge clk);
        #3 reset = 1'b0;
        #2;
        chk("midrst_data", rx_data, 8'h00);
        chk("midrst_empty", rx_empty, 1);
        chk("midrst_ferr", rx_frame_err, 0);
        chk("midrst_ovr", rx_overrun, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
      end
    join
    exp_q.push_back(8'h12);
    send(8'h12, 1'b1);
    chk("postrst_data", rx_data, 8'h12);
    chk("postrst_empty", rx_empty, 0);
    unload();

    // Unload edge coincident with completion of 0x77, 0x66 pending
    exp_q.push_back(8'h66);
    send(8'h66, 1'b1);
    exp_q.push_back(8'h77);
    fork
      send(8'h77, 1'b1);
      begin
        repeat (1523) @(posedge clk);
        #1 uld_rx_data = 1'b1;
        @(posedge clk);
        #1 uld_rx_data = 1'b0;
      end
    join
    chk("simul_data", rx_data, 8'h77);
    chk("simul_empty", rx_empty, 0);
    chk("simul_ovr", rx_overrun, 0);
    unload();

    // Disable mid-frame: nothing lands
    fork
      send(8'h5A, 1'b1);
      begin
        repeat (400) @(posedge clk);
        #1 rx_enable = 1'b0;
      end
    join
    repeat (20) @(posedge clk);
    #1 rx_enable = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("dis_empty", rx_empty, 1);
    chk("dis_ferr", rx_frame_err, 0);
    chk("dis_ovr", rx_overrun, 0);
    chk("dis_data", rx_data, 8'h77);

    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
